// File: rtl/counter_load_arbiter.sv
// Round-robin owner of a shared loadable up-counter: grants one requester,
// loads its start value, waits for the terminal count, then pulses done.
module counter_load_arbiter #(
  parameter int                 NREQ  = 4,
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TERM  = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    cnt_load,
  output logic [WIDTH-1:0]        cnt_data,
  input  logic [WIDTH-1:0]        cnt_value
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [IDXW-1:0]     ptr_r, ptr_nxt_s;
  logic [IDXW-1:0]     owner_r, owner_nxt_s;
  logic [IDXW-1:0]     pick_s;
  logic [WIDTH-1:0]    data_r, data_nxt_s;
  logic [NREQ-1:0]     grant_r, grant_nxt_s;
  logic [NREQ-1:0]     done_r, done_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                cnt_load_r, cnt_load_nxt_s;
  logic [WIDTH-1:0]    cnt_data_r, cnt_data_nxt_s;

  // First set request at or after the pointer, wrapping modulo NREQ.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] p);
    logic [IDXW-1:0] sel;
    logic            found;
    int              idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found && r[IDXW'(idx)]) begin
        sel   = IDXW'(idx);
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == IDXW'(NREQ - 1)) ? IDXW'(0) : i + IDXW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign pick_s = rr_pick(req, ptr_r);

  // State, arbitration bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      owner_r    <= '0;
      data_r     <= '0;
      grant_r    <= '0;
      done_r     <= '0;
      busy_r     <= 1'b0;
      cnt_load_r <= 1'b0;
      cnt_data_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      owner_r    <= owner_nxt_s;
      data_r     <= data_nxt_s;
      grant_r    <= grant_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
      cnt_load_r <= cnt_load_nxt_s;
      cnt_data_r <= cnt_data_nxt_s;
    end
  end

  // Next state; an owner dropping its request in RUN wins over terminal count.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    owner_nxt_s = owner_r;
    data_nxt_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          owner_nxt_s = pick_s;
          data_nxt_s  = req_data[int'(pick_s)*WIDTH +: WIDTH];
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (!req[owner_r]) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = next_idx(owner_r);
        end else if (cnt_value == TERM) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = next_idx(owner_r);
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, registered on the next edge.
  always_comb begin
    grant_nxt_s    = '0;
    done_nxt_s     = '0;
    busy_nxt_s     = 1'b0;
    cnt_load_nxt_s = 1'b0;
    cnt_data_nxt_s = cnt_data_r;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_LOAD: begin
        grant_nxt_s    = onehot(owner_nxt_s);
        busy_nxt_s     = 1'b1;
        cnt_load_nxt_s = 1'b1;
        cnt_data_nxt_s = data_nxt_s;
      end
      ST_RUN: begin
        grant_nxt_s = onehot(owner_nxt_s);
        busy_nxt_s  = 1'b1;
      end
      ST_DONE: begin
        grant_nxt_s = onehot(owner_nxt_s);
        done_nxt_s  = onehot(owner_nxt_s);
        busy_nxt_s  = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  assign grant    = grant_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign cnt_load = cnt_load_r;
  assign cnt_data = cnt_data_r;

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Directed bench: vector table for single/abort/shortest intervals, plus
// hand-written sequences for async reset, contention and counter wrap.
module tb_counter_load_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'h0, req2 = 4'h0;
  logic [15:0] req_data = 16'h0, req_data2 = 16'h0;
  logic [3:0]  grant, done, cnt_data, cnt_value;
  logic [3:0]  grant2, done2, cnt_data2, cnt_value2;
  logic        busy, cnt_load, busy2, cnt_load2;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        load;
    logic [3:0]  cdata;
  } vec_t;

  vec_t vecs[$];

  counter_load_arbiter #(.NREQ(4), .WIDTH(4), .TERM(4'hF)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .busy(busy),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_value(cnt_value)
  );

  counter_load_arbiter #(.NREQ(4), .WIDTH(4), .TERM(4'h3)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2),
    .grant(grant2), .done(done2), .busy(busy2),
    .cnt_load(cnt_load2), .cnt_data(cnt_data2), .cnt_value(cnt_value2)
  );

  always #5 clk = ~clk;

  // The shared 4-bit counters the arbiters drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_value  <= 4'h0;
      cnt_value2 <= 4'h0;
    end else begin
      cnt_value  <= cnt_load  ? cnt_data  : cnt_value  + 4'h1;
      cnt_value2 <= cnt_load2 ? cnt_data2 : cnt_value2 + 4'h1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic [15:0] d,
                              input logic [3:0] g, input logic [3:0] dn, input logic b,
                              input logic l, input logic [3:0] cd);
    vec_t v;
    v.rst = r; v.req = rq; v.data = d; v.grant = g; v.done = dn;
    v.busy = b; v.load = l; v.cdata = cd;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0] exp_g;
    int         exp_own[5];
    int         n;
    exp_own = '{0, 1, 2, 3, 0};

    // reset
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);
    // single, D=13 on req[0]; data changes after grant must be ignored
    add(1'b1, 4'b0001, 16'h000D, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'hD);
    add(1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'hD);
    add(1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'hD);
    add(1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'hD);
    add(1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'hD);
    add(1'b1, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'hD);
    add(1'b1, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'hD);
    // reset, then D=TERM on req[1] (shortest interval)
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);
    add(1'b1, 4'b0010, 16'h00F0, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'hF);
    add(1'b1, 4'b0010, 16'h00F0, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'hF);
    add(1'b1, 4'b0010, 16'h00F0, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'hF);
    add(1'b1, 4'b0000, 16'h00F0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'hF);
    // reset, then abort of req[2] in RUN; pointer moves past 2 so 3 beats 0
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);
    add(1'b1, 4'b1100, 16'h5200, 4'b0100, 4'b0000, 1'b1, 1'b1, 4'h2);
    add(1'b1, 4'b1100, 16'h5200, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'h2);
    add(1'b1, 4'b1000, 16'h5200, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h2);
    add(1'b1, 4'b1001, 16'h5200, 4'b1000, 4'b0000, 1'b1, 1'b1, 4'h5);
    add(1'b1, 4'b1001, 16'h5200, 4'b1000, 4'b0000, 1'b1, 1'b0, 4'h5);
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);

    #1;
    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      req      = vecs[i].req;
      req_data = vecs[i].data;
      step();
      chk($sformatf("row%0d grant", i), {12'h0, grant},    {12'h0, vecs[i].grant});
      chk($sformatf("row%0d done", i),  {12'h0, done},     {12'h0, vecs[i].done});
      chk($sformatf("row%0d busy", i),  {15'h0, busy},     {15'h0, vecs[i].busy});
      chk($sformatf("row%0d load", i),  {15'h0, cnt_load}, {15'h0, vecs[i].load});
      chk($sformatf("row%0d cdata", i), {12'h0, cnt_data}, {12'h0, vecs[i].cdata});
    end

    // asynchronous reset in the middle of RUN
    rst = 1'b1; req = 4'b0001; req_data = 16'h0000;
    step(); step(); step();
    chk("midrun busy before reset", {15'h0, busy}, 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst grant", {12'h0, grant},    16'h0000);
    chk("async rst done",  {12'h0, done},     16'h0000);
    chk("async rst busy",  {15'h0, busy},     16'h0000);
    chk("async rst load",  {15'h0, cnt_load}, 16'h0000);
    chk("async rst cdata", {12'h0, cnt_data}, 16'h0000);
    step();
    rst = 1'b1; req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("post rst done c%0d", c), {12'h0, done}, 16'h0000);
      chk($sformatf("post rst busy c%0d", c), {15'h0, busy}, 16'h0000);
    end

    // contention: all four request with D=14, rotation 0,1,2,3,0
    req = 4'b1111; req_data = 16'hEEEE;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << exp_own[k];
      step();
      n = 1;
      while (grant == 4'h0 && n < 8) begin
        step();
        n++;
      end
      chk($sformatf("rr%0d grant", k), {12'h0, grant},    {12'h0, exp_g});
      chk($sformatf("rr%0d load", k),  {15'h0, cnt_load}, 16'h0001);
      chk($sformatf("rr%0d cdata", k), {12'h0, cnt_data}, 16'h000E);
      n = 0;
      while (done == 4'h0 && n < 8) begin
        step();
        n++;
      end
      chk($sformatf("rr%0d latency", k), n[15:0], 16'h0003);
      chk($sformatf("rr%0d done", k), {12'h0, done}, {12'h0, exp_g});
      step();
      chk($sformatf("rr%0d gap grant", k), {12'h0, grant}, 16'h0000);
      chk($sformatf("rr%0d gap done", k),  {12'h0, done},  16'h0000);
    end
    req = 4'b0000;

    // counter wrap with TERM=3 and D=15
    req2 = 4'b0001; req_data2 = 16'h000F;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("wrap done c%0d", c), {12'h0, done2}, (c == 6) ? 16'h0001 : 16'h0000);
      if (c == 0) begin
        chk("wrap load", {15'h0, cnt_load2}, 16'h0001);
        chk("wrap grant", {12'h0, grant2}, 16'h0001);
      end
      if (c == 6) begin
        req2 = 4'b0000;
      end
      if (c == 7) begin
        chk("wrap release", {12'h0, grant2}, 16'h0000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
